// File: rtl/spike_aer_encoder.sv
// spike_aer_encoder
//   Collects 1-bit spikes from N_NEURONS neurons into per-neuron pending latches,
//   picks one pending neuron per cycle with a round-robin arbiter, queues its
//   address in a small FIFO and presents the FIFO head as a valid/ready AER stream.
//   Optional feature macro: SPIKE_TIMESTAMP_EN adds tick_i / aer_ts_o and stores a
//   timestep counter value alongside each queued address.
module spike_aer_encoder #(
    parameter int N_NEURONS  = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int TS_WIDTH   = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [N_NEURONS-1:0]         spike_i,
    output logic                         aer_valid_o,
    input  logic                         aer_ready_i,
    output logic [$clog2(N_NEURONS)-1:0] aer_addr_o,
    output logic                         overflow_o
`ifdef SPIKE_TIMESTAMP_EN
    ,
    input  logic                         tick_i,
    output logic [TS_WIDTH-1:0]          aer_ts_o
`endif
);

    localparam int AW = $clog2(N_NEURONS);
    localparam int PW = $clog2(FIFO_DEPTH);
`ifdef SPIKE_TIMESTAMP_EN
    localparam int TSW = TS_WIDTH;
`else
    localparam int TSW = 0;
`endif
    localparam int EW = AW + TSW;
    localparam logic [PW:0] DEPTH_C = FIFO_DEPTH[PW:0];

    // (a + b) mod N_NEURONS for a < N_NEURONS and 0 <= b < N_NEURONS.
    function automatic logic [AW-1:0] add_mod(input logic [AW-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= N_NEURONS) s = s - N_NEURONS;
        return AW'(s);
    endfunction

    logic [N_NEURONS-1:0] pending;
    logic [AW-1:0]        rr_ptr;
    logic [EW-1:0]        mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [PW:0]          count;

    logic                 grant_valid;
    logic [AW-1:0]        grant_idx;
    logic [N_NEURONS-1:0] grant_onehot;
    logic                 push;
    logic                 pop;
    logic [EW-1:0]        push_data;
    logic [EW-1:0]        head;

    // Round-robin search over the pending register, starting at rr_ptr.
    // A pop in this cycle does not free a slot for this cycle's grant.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves
        // a value unassigned and no latch is inferred.
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (count < DEPTH_C) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                if (!grant_valid && pending[add_mod(rr_ptr, i)]) begin
                    grant_valid = 1'b1;
                    grant_idx   = add_mod(rr_ptr, i);
                end
            end
        end
    end

    assign grant_onehot = grant_valid ? ({{(N_NEURONS-1){1'b0}}, 1'b1} << grant_idx) : '0;
    assign push         = grant_valid;
    assign aer_valid_o  = (count != '0);
    assign pop          = aer_valid_o & aer_ready_i;
    assign head         = mem[rd_ptr];
    assign aer_addr_o   = head[AW-1:0];

`ifdef SPIKE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_cnt;

    // Timestep counter; wraps naturally at 2^TS_WIDTH.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)       ts_cnt <= '0;
        else if (tick_i) ts_cnt <= ts_cnt + TS_WIDTH'(1);
    end

    assign push_data = {ts_cnt, grant_idx};
    assign aer_ts_o  = head[EW-1:AW];
`else
    assign push_data = grant_idx;
`endif

    // Pending latches, sticky overflow and round-robin pointer.
    // A granted neuron that spikes again in its grant cycle simply re-arms.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending    <= '0;
            overflow_o <= 1'b0;
            rr_ptr     <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every register
            // here samples the pre-edge values, independent of statement order.
            pending    <= (pending & ~grant_onehot) | spike_i;
            overflow_o <= overflow_o | (|(spike_i & pending & ~grant_onehot));
            if (grant_valid) rr_ptr <= add_mod(grant_idx, 1);
        end
    end

    // Event FIFO: storage, pointers and occupancy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: the storage is cleared too so the head (and aer_addr_o) reads as
            // zero out of reset instead of X; the array is only a few words.
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + (PW+1)'(1);
            else if (pop && !push) count <= count - (PW+1)'(1);
        end
    end

endmodule

// File: tb/tb_spike_aer_encoder.sv
// tb_spike_aer_encoder
//   Directed bench for spike_aer_encoder (N_NEURONS=16, FIFO_DEPTH=8).
//   With SPIKE_TIMESTAMP_EN defined, TS_WIDTH=2 is used to exercise counter wrap.
module tb_spike_aer_encoder;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [15:0] spike_i = '0;
    logic        aer_ready_i = 1'b0;
    logic        aer_valid_o;
    logic [3:0]  aer_addr_o;
    logic        overflow_o;
`ifdef SPIKE_TIMESTAMP_EN
    logic        tick_i = 1'b0;
    logic [1:0]  aer_ts_o;
`endif

    int n_asserts = 0;
    int n_fail    = 0;

    spike_aer_encoder #(
        .N_NEURONS (16),
        .FIFO_DEPTH(8),
`ifdef SPIKE_TIMESTAMP_EN
        .TS_WIDTH  (2)
`else
        .TS_WIDTH  (16)
`endif
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .spike_i    (spike_i),
        .aer_valid_o(aer_valid_o),
        .aer_ready_i(aer_ready_i),
        .aer_addr_o (aer_addr_o),
        .overflow_o (overflow_o)
`ifdef SPIKE_TIMESTAMP_EN
        ,
        .tick_i     (tick_i),
        .aer_ts_o   (aer_ts_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past one rising edge; sample 1 time unit after it.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Short async reset pulse placed between edges.
    task automatic pulse_reset();
        rst_i = 1'b1;
        #2;
        rst_i = 1'b0;
    endtask

    initial begin
        // Reset state
        #1 rst_i = 1'b1;
        #2;
        check("rst_valid", aer_valid_o, 1'b0);
        check("rst_addr", aer_addr_o, 4'd0);
        check("rst_ovf", overflow_o, 1'b0);
        #5 rst_i = 1'b0;
        cyc();

        // 1. Single spike on neuron 4
        aer_ready_i = 1'b1;
        spike_i = 16'h0010;
        cyc();
        spike_i = '0;
        check("t1_valid_e0", aer_valid_o, 1'b0);
        cyc();
        check("t1_valid_e1", aer_valid_o, 1'b1);
        check("t1_addr", aer_addr_o, 4'd4);
        check("t1_ovf", overflow_o, 1'b0);
        cyc();
        check("t1_valid_after", aer_valid_o, 1'b0);

        // 2. Burst on all neurons, consumer always ready
        pulse_reset();
        spike_i = 16'hFFFF;
        cyc();
        spike_i = '0;
        check("t2_valid_e0", aer_valid_o, 1'b0);
        for (int i = 0; i < 16; i++) begin
            cyc();
            check($sformatf("t2_valid_%0d", i), aer_valid_o, 1'b1);
            check($sformatf("t2_addr_%0d", i), aer_addr_o, 32'(i));
        end
        cyc();
        check("t2_valid_end", aer_valid_o, 1'b0);
        check("t2_ovf", overflow_o, 1'b0);

        // 3. Backpressure: FIFO fills with 0..7, 8..15 wait in pending
        pulse_reset();
        aer_ready_i = 1'b0;
        spike_i = 16'hFFFF;
        cyc();
        spike_i = '0;
        repeat (8) cyc();
        check("t3_valid_full", aer_valid_o, 1'b1);
        check("t3_addr_full", aer_addr_o, 4'd0);
        check("t3_ovf_before", overflow_o, 1'b0);
        cyc();
        check("t3_addr_stable", aer_addr_o, 4'd0);
        spike_i = 16'h0100;
        cyc();
        spike_i = '0;
        check("t3_ovf_set", overflow_o, 1'b1);
        aer_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t3_valid_%0d", i), aer_valid_o, 1'b1);
            check($sformatf("t3_addr_%0d", i), aer_addr_o, 32'(i));
            cyc();
        end
        check("t3_valid_end", aer_valid_o, 1'b0);
        check("t3_ovf_sticky", overflow_o, 1'b1);

        // 4. Round-robin fairness between neurons 3 and 5 held high
        pulse_reset();
        spike_i = 16'h0028;
        cyc();
        for (int i = 0; i < 6; i++) begin
            cyc();
            check($sformatf("t4_valid_%0d", i), aer_valid_o, 1'b1);
            check($sformatf("t4_addr_%0d", i), aer_addr_o, (i % 2 == 0) ? 32'd3 : 32'd5);
        end
        spike_i = '0;

        // 5. Async reset with a non-empty FIFO and overflow set
        pulse_reset();
        aer_ready_i = 1'b0;
        spike_i = 16'h0003;
        cyc();
        cyc();
        spike_i = '0;
        cyc();
        check("t5_valid_pre", aer_valid_o, 1'b1);
        check("t5_ovf_pre", overflow_o, 1'b1);
        #2 rst_i = 1'b1;
        #1;
        check("t5_valid_rst", aer_valid_o, 1'b0);
        check("t5_ovf_rst", overflow_o, 1'b0);
        rst_i = 1'b0;
        aer_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check($sformatf("t5_quiet_%0d", i), aer_valid_o, 1'b0);
        end

`ifdef SPIKE_TIMESTAMP_EN
        // 6. Timestamps: three ticks then a spike, then wrap 3 -> 0
        pulse_reset();
        aer_ready_i = 1'b0;
        tick_i = 1'b1;
        repeat (3) cyc();
        tick_i = 1'b0;
        spike_i = 16'h0001;
        cyc();
        spike_i = '0;
        cyc();
        check("t6_valid", aer_valid_o, 1'b1);
        check("t6_addr", aer_addr_o, 4'd0);
        check("t6_ts", aer_ts_o, 2'd3);
        aer_ready_i = 1'b1;
        tick_i = 1'b1;
        spike_i = 16'h0002;
        cyc();
        tick_i = 1'b0;
        spike_i = '0;
        cyc();
        check("t6_valid_wrap", aer_valid_o, 1'b1);
        check("t6_addr_wrap", aer_addr_o, 4'd1);
        check("t6_ts_wrap", aer_ts_o, 2'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
